aes_128_dec_iter: RTL and testbench

Iterative AES-128 decryption core: the receive-side counterpart of the unrolled `aes_128` encryption pipeline. It accepts one ciphertext/key pair over a valid/ready handshake, runs the key schedule forward to round key 10, then performs ten inverse rounds while stepping the key schedule backward one round per cycle. It presents the plaintext on a valid/ready output. It trades throughput for area (one block in flight) and sits on the receive path opposite the encryptor.

---
 rtl/aes_pkg.sv | 74 +++++++
 rtl/aes_128_dec_iter_if.sv | 23 ++
 rtl/aes_inv_round.sv | 40 ++++
 rtl/aes_128_dec_iter.sv | 120 ++++++++++++
 tb/tb_aes_128_dec_iter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative decryption core.
// Contents: FSM state type, round-constant table, forward and inverse S-box
// functions, and the GF(2^8) helpers used by InvMixColumns.
// No ports; imported by the interface users and sub-modules.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUNDS, DONE} state_t;

    localparam logic [7:0] rcon [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply, exponent 1111_1110b);
    // maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, a);
        end
        return r;
    endfunction

    // S-boxes are computed rather than tabulated so both stay combinational.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] t;
        t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] mul_9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul_b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul_d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul_e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage

// File: rtl/aes_128_dec_iter_if.sv
// Handshake bundle for aes_128_dec_iter.
// Input side : in_valid/in_ready with ct and key (128 bits, byte 0 = MSB).
// Output side: out_valid/out_ready with pt.
// master = block feeding ciphertext and consuming plaintext; slave = core.
interface aes_128_dec_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ct;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] pt;

    modport master (
        output in_valid, ct, key, out_ready,
        input  in_ready, out_valid, pt
    );

    modport slave (
        input  in_valid, ct, key, out_ready,
        output in_ready, out_valid, pt
    );
endinterface

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round.
// Ports: state_in  - current state (byte 0 = bits 127:120, column-major)
//        round_key - key added after InvSubBytes
//        last      - skip InvMixColumns for the final round
//        state_out - next state
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [7:0] sb [16];
    logic [7:0] ak [16];

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            // byte k is row k%4, column k/4; row r is rotated right by r
            sb[k] = inv_sbox(state_in[127 - 8 * ((k % 4) + 4 * (((k / 4) - (k % 4) + 4) % 4)) -: 8]);
            ak[k] = sb[k] ^ round_key[127 - 8 * k -: 8];
        end
    end

    always_comb begin
        state_out = '0;
        for (int c = 0; c < 4; c++) begin
            if (last) begin
                state_out[127 - 32 * c -: 32] = {ak[4*c], ak[4*c+1], ak[4*c+2], ak[4*c+3]};
            end else begin
                state_out[127 - 32 * c      -: 8] = mul_e(ak[4*c]) ^ mul_b(ak[4*c+1]) ^ mul_d(ak[4*c+2]) ^ mul_9(ak[4*c+3]);
                state_out[127 - 32 * c - 8  -: 8] = mul_9(ak[4*c]) ^ mul_e(ak[4*c+1]) ^ mul_b(ak[4*c+2]) ^ mul_d(ak[4*c+3]);
                state_out[127 - 32 * c - 16 -: 8] = mul_d(ak[4*c]) ^ mul_9(ak[4*c+1]) ^ mul_e(ak[4*c+2]) ^ mul_b(ak[4*c+3]);
                state_out[127 - 32 * c - 24 -: 8] = mul_b(ak[4*c]) ^ mul_d(ak[4*c+1]) ^ mul_9(ak[4*c+2]) ^ mul_e(ak[4*c+3]);
            end
        end
    end

endmodule

// File: rtl/aes_128_dec_iter.sv
// Iterative AES-128 decryption core, one block in flight.
// Ports: clk, rst_n (async, active-low), bus (slave side of
//        aes_128_dec_iter_if: in_valid/in_ready/ct/key, out_valid/out_ready/pt).
// Runs the key schedule forward to rk10 (10 cycles), then ten inverse rounds
// while walking the schedule back one round key per cycle (10 cycles).
//
// state  | meaning
// IDLE   | waiting for a ciphertext/key pair, in_ready high
// KEYEXP | forward key expansion, cnt = step index 0..9
// ROUNDS | inverse rounds, cnt = round key index 9..0
// DONE   | pt valid, held until out_ready
module aes_128_dec_iter
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    aes_128_dec_iter_if.slave bus
);

    state_t       fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] key_q, key_d;
    logic [127:0] state_q, state_d;
    logic [127:0] pt_q, pt_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  f0, f1, f2, f3;
    logic [31:0]  i0, i1, i2, i3;
    logic [127:0] key_fwd, key_inv;
    logic [127:0] round_out;
    logic         last_round;

    assign {w0, w1, w2, w3} = key_q;

    always_comb begin
        f0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rcon[cnt_q], 24'h0};
        f1 = w1 ^ f0;
        f2 = w2 ^ f1;
        f3 = w3 ^ f2;
        // undo the step that produced key_q: recover words d..b first, then a
        i3 = w3 ^ w2;
        i2 = w2 ^ w1;
        i1 = w1 ^ w0;
        i0 = w0 ^ sub_word({i3[23:0], i3[31:24]}) ^ {rcon[cnt_q], 24'h0};
    end

    assign key_fwd    = {f0, f1, f2, f3};
    assign key_inv    = {i0, i1, i2, i3};
    assign last_round = (cnt_q == 4'd0);

    aes_inv_round u_inv_round (
        .state_in  (state_q),
        .round_key (key_inv),
        .last      (last_round),
        .state_out (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            cnt_q   <= 4'd0;
            key_q   <= '0;
            state_q <= '0;
            pt_q    <= '0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            state_q <= state_d;
            pt_q    <= pt_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        state_d = state_q;
        pt_d    = pt_q;
        case (fsm_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // state register holds ct until rk10 is available
                    state_d = bus.ct;
                    key_d   = bus.key;
                    cnt_d   = 4'd0;
                    fsm_d   = KEYEXP;
                end
            end
            KEYEXP: begin
                key_d = key_fwd;
                if (cnt_q == 4'd9) begin
                    state_d = state_q ^ key_fwd;
                    fsm_d   = ROUNDS;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ROUNDS: begin
                key_d   = key_inv;
                state_d = round_out;
                if (last_round) begin
                    pt_d  = round_out;
                    fsm_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (fsm_q == IDLE);
    assign bus.out_valid = (fsm_q == DONE);
    assign bus.pt        = pt_q;

endmodule

// File: tb/tb_aes_128_dec_iter.sv
// Directed bench for aes_128_dec_iter using published AES-128 vectors.
module tb_aes_128_dec_iter;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    aes_128_dec_iter_if bus ();

    aes_128_dec_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_E1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] PT_E1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT_E2 = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] PT_E2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // called at posedge+1 with the core idle; returns at accept edge + 1
    task automatic start(input logic [127:0] c, input logic [127:0] k);
        bus.in_valid = 1'b1;
        bus.ct       = c;
        bus.key      = k;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int k);
        k = 0;
        while (!bus.out_valid && k < 64) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    int   lat;
    logic low_ok;
    logic stable;

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.ct        = '0;
        bus.key       = '0;
        bus.out_ready = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_pt", bus.pt, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);

        // FIPS-197 App. B with latency
        start(CT_B, KEY_B);
        check("b_in_ready_busy", bus.in_ready, 1'b0);
        wait_out(lat);
        check("b_latency", 128'(lat), 128'd20);
        check("b_pt", bus.pt, PT_B);
        handshake();
        check("b_out_valid_after", bus.out_valid, 1'b0);
        check("b_in_ready_after", bus.in_ready, 1'b1);

        // backpressure with input noise
        start(CT_E1, KEY_B);
        wait_out(lat);
        check("bp_latency", 128'(lat), 128'd20);
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            bus.ct       = {$urandom, $urandom, $urandom, $urandom};
            bus.key      = {$urandom, $urandom, $urandom, $urandom};
            bus.in_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            stable &= (bus.pt === PT_E1) && (bus.out_valid === 1'b1) && (bus.in_ready === 1'b0);
        end
        bus.in_valid = 1'b0;
        check("bp_stable", stable, 1'b1);
        check("bp_pt", bus.pt, PT_E1);
        handshake();
        check("bp_released", bus.out_valid, 1'b0);

        // back-to-back: in_valid held, inputs swapped to the second vector after accept
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.ct        = CT_C;
        bus.key       = KEY_C;
        @(posedge clk);
        #1;
        bus.ct  = CT_E2;
        bus.key = KEY_B;
        lat     = 0;
        low_ok  = 1'b1;
        while (!bus.out_valid && lat < 64) begin
            low_ok &= !bus.in_ready;
            @(posedge clk);
            #1;
            lat++;
        end
        check("bb1_latency", 128'(lat), 128'd20);
        check("bb1_in_ready_low", low_ok, 1'b1);
        check("bb1_in_ready_done", bus.in_ready, 1'b0);
        check("bb1_pt", bus.pt, PT_C);
        @(posedge clk);
        #1;
        check("bb_gap_in_ready", bus.in_ready, 1'b1);
        check("bb_gap_out_valid", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bb2_accepted", bus.in_ready, 1'b0);
        wait_out(lat);
        check("bb2_latency", 128'(lat), 128'd20);
        check("bb2_pt", bus.pt, PT_E2);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bb2_done", bus.out_valid, 1'b0);

        // reset during key expansion
        start(CT_B, KEY_B);
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("r7_out_valid", bus.out_valid, 1'b0);
        check("r7_pt", bus.pt, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("r7_in_ready", bus.in_ready, 1'b1);

        // reset during the inverse rounds
        start(CT_B, KEY_B);
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("r15_out_valid", bus.out_valid, 1'b0);
        check("r15_pt", bus.pt, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("r15_in_ready", bus.in_ready, 1'b1);

        // fresh vector after the aborted ones
        start(CT_B, KEY_B);
        wait_out(lat);
        check("post_rst_latency", 128'(lat), 128'd20);
        check("post_rst_pt", bus.pt, PT_B);
        handshake();
        check("post_rst_idle", bus.in_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
